// File: rtl/fib_seq_pkg.sv
// Shared types and constants for the generalised-Fibonacci sequence engine.
package fib_seq_pkg;

    // Controller states; the 2'b11 encoding is unused and recovers to idle.
    typedef enum logic [1:0] {
        e_idle    = 2'b00,
        e_operate = 2'b01,
        e_done    = 2'b10
    } state_e;

    // Seed selection; 2'b11 is reserved and falls back to Fibonacci seeds.
    typedef enum logic [1:0] {
        FIB    = 2'b00,
        LUCAS  = 2'b01,
        CUSTOM = 2'b10
    } mode_e;

    // Lucas numbers start from T(0)=2, T(1)=1.
    localparam int LUCAS_SEED0 = 2;
    localparam int LUCAS_SEED1 = 1;

endpackage

// File: rtl/fib_sat_add.sv
// Saturating adder for sequence terms: once either operand has already
// overflowed, or the new sum carries out, the result pins at all-ones.
module fib_sat_add #(
    parameter int W = 20
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         a_ovf,
    input  logic         b_ovf,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] raw_sum;

    // Widen by one bit so the carry is visible, then clamp instead of wrapping.
    always_comb begin
        raw_sum = {1'b0, a} + {1'b0, b};
        ovf     = a_ovf | b_ovf | raw_sum[W];
        sum     = ovf ? '1 : raw_sum[W-1:0];
    end

endmodule

// File: rtl/fib_seq.sv
// Generalised-Fibonacci sequence engine: start/ready/done slave that streams
// T(0)..T(n) from a selectable seed pair and latches T(n) with a sticky
// saturation flag.
module fib_seq
    import fib_seq_pkg::*;
#(
    parameter int W   = 20,
    parameter int N_W = 5
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic           i_abort,
    input  logic [1:0]     i_mode,
    input  logic [W-1:0]   i_seed0,
    input  logic [W-1:0]   i_seed1,
    input  logic [N_W-1:0] i_n,
    output logic           o_ready,
    output logic [W-1:0]   o_term,
    output logic [N_W-1:0] o_term_idx,
    output logic           o_term_valid,
    output logic           o_done_tick,
    output logic [W-1:0]   o_result,
    output logic           o_ovf
);

    state_e         state;
    state_e         state_next;

    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           a_ovf;
    logic           b_ovf;
    logic [N_W-1:0] k;
    logic [N_W-1:0] n;
    logic [W-1:0]   result;
    logic           ovf;

    logic [W-1:0]   sum;
    logic           sum_ovf;
    logic           at_target;

    assign at_target = (k == n);

    fib_sat_add #(.W(W)) u_add (
        .a     (a),
        .b     (b),
        .a_ovf (a_ovf),
        .b_ovf (b_ovf),
        .sum   (sum),
        .ovf   (sum_ovf)
    );

    // State register; reset forces idle immediately without a done tick.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= e_idle;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: abort wins over completion, done lasts one cycle.
    always_comb begin
        state_next = e_idle;
        case (state)
            e_idle: begin
                state_next = i_start ? e_operate : e_idle;
            end
            e_operate: begin
                if (i_abort) begin
                    state_next = e_idle;
                end else if (at_target) begin
                    state_next = e_done;
                end else begin
                    state_next = e_operate;
                end
            end
            e_done: begin
                state_next = e_idle;
            end
            default: begin
                state_next = e_idle;
            end
        endcase
    end

    // Datapath: load seeds on start, advance the term pair while operating,
    // and latch the final term only on a non-aborted completion.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a      <= '0;
            b      <= '0;
            a_ovf  <= 1'b0;
            b_ovf  <= 1'b0;
            k      <= '0;
            n      <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                e_idle: begin
                    if (i_start) begin
                        case (i_mode)
                            LUCAS: begin
                                a <= W'(LUCAS_SEED0);
                                b <= W'(LUCAS_SEED1);
                            end
                            CUSTOM: begin
                                a <= i_seed0;
                                b <= i_seed1;
                            end
                            default: begin
                                a <= '0;
                                b <= W'(1);
                            end
                        endcase
                        a_ovf <= 1'b0;
                        b_ovf <= 1'b0;
                        k     <= '0;
                        n     <= i_n;
                    end
                end
                e_operate: begin
                    if (!i_abort) begin
                        if (at_target) begin
                            result <= a;
                            ovf    <= a_ovf;
                        end else begin
                            a     <= b;
                            a_ovf <= b_ovf;
                            b     <= sum;
                            b_ovf <= sum_ovf;
                            k     <= k + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from the state plus the registered datapath.
    always_comb begin
        o_ready      = (state == e_idle);
        o_term_valid = (state == e_operate);
        o_done_tick  = (state == e_done);
        o_term       = a;
        o_term_idx   = k;
        o_result     = result;
        o_ovf        = ovf;
    end

endmodule

// File: tb/tb_fib_seq.sv
// Directed testbench for fib_seq: each task drives one scenario and checks
// the streamed terms, completion timing and latched result against
// hand-computed values.
module tb_fib_seq;

    localparam int W   = 20;
    localparam int N_W = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic [1:0]     mode;
    logic [W-1:0]   seed0;
    logic [W-1:0]   seed1;
    logic [N_W-1:0] n_in;
    logic           ready;
    logic [W-1:0]   term;
    logic [N_W-1:0] term_idx;
    logic           term_valid;
    logic           done_tick;
    logic [W-1:0]   result;
    logic           ovf;

    int vectors     = 0;
    int miscompares = 0;

    // Capture buffers filled by run_seq.
    logic [W-1:0]   term_log [64];
    logic [N_W-1:0] idx_log  [64];
    int             term_count;
    int             done_cycle;
    logic [W-1:0]   run_result;
    logic           run_ovf;
    logic           ready_seen;

    fib_seq #(.W(W), .N_W(N_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_abort      (abort),
        .i_mode       (mode),
        .i_seed0      (seed0),
        .i_seed1      (seed1),
        .i_n          (n_in),
        .o_ready      (ready),
        .o_term       (term),
        .o_term_idx   (term_idx),
        .o_term_valid (term_valid),
        .o_done_tick  (done_tick),
        .o_result     (result),
        .o_ovf        (ovf)
    );

    always #5 clk = ~clk;

    // Launch one computation and record the stream. Cycle 1 is the cycle
    // after the start edge; done_cycle stays -1 if no tick within budget.
    // Returns sampling inside the done cycle.
    task automatic run_seq(input logic [1:0] m, input logic [W-1:0] s0,
                           input logic [W-1:0] s1, input logic [N_W-1:0] nn);
        @(posedge clk); #1;
        ready_seen = ready;
        mode  = m;
        seed0 = s0;
        seed1 = s1;
        n_in  = nn;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 2'b10;
        seed0 = '1;
        seed1 = '1;
        n_in  = '0;
        term_count = 0;
        done_cycle = -1;
        run_result = 'x;
        run_ovf    = 1'bx;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (term_valid && term_count < 64) begin
                term_log[term_count] = term;
                idx_log[term_count]  = term_idx;
                term_count++;
            end
            if (done_tick) begin
                done_cycle = cyc;
                run_result = result;
                run_ovf    = ovf;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got %0b want 1", ready); end
        vectors++;
        if (term_valid !== 1'b0 || done_tick !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_strobes got valid=%0b done=%0b want 0/0", term_valid, done_tick); end
        vectors++;
        if (result !== '0 || ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_result got %0h/%0b want 0/0", result, ovf); end
        vectors++;
        if (term !== '0 || term_idx !== '0) begin miscompares++; $display("[TB] FAIL reset_term got %0h/%0d want 0/0", term, term_idx); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fib_n0();
        run_seq(2'b00, '0, '0, 5'd0);
        vectors++;
        if (done_cycle != 2) begin miscompares++; $display("[TB] FAIL fib0_latency got %0d want 2", done_cycle); end
        vectors++;
        if (term_count != 1 || term_log[0] !== '0 || idx_log[0] !== '0) begin miscompares++; $display("[TB] FAIL fib0_stream got count=%0d term=%0h idx=%0d want 1/0/0", term_count, term_log[0], idx_log[0]); end
        vectors++;
        if (run_result !== '0 || run_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL fib0_result got %0h/%0b want 0/0", run_result, run_ovf); end
    endtask

    task automatic test_fib_n10();
        int exp_terms [11] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
        run_seq(2'b00, '0, '0, 5'd10);
        vectors++;
        if (done_cycle != 12) begin miscompares++; $display("[TB] FAIL fib10_latency got %0d want 12", done_cycle); end
        vectors++;
        if (term_count != 11) begin miscompares++; $display("[TB] FAIL fib10_count got %0d want 11", term_count); end
        for (int i = 0; i < 11; i++) begin
            vectors++;
            if (term_log[i] !== W'(exp_terms[i]) || idx_log[i] !== N_W'(i)) begin
                miscompares++;
                $display("[TB] FAIL fib10_term%0d got %0d@%0d want %0d@%0d", i, term_log[i], idx_log[i], exp_terms[i], i);
            end
        end
        vectors++;
        if (run_result !== W'(55) || run_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL fib10_result got %0d/%0b want 55/0", run_result, run_ovf); end
        @(posedge clk); #1;
        vectors++;
        if (ready !== 1'b1 || done_tick !== 1'b0) begin miscompares++; $display("[TB] FAIL fib10_ready_after got ready=%0b done=%0b want 1/0", ready, done_tick); end
    endtask

    task automatic test_lucas_and_mode3();
        int exp_terms [6] = '{2, 1, 3, 4, 7, 11};
        run_seq(2'b01, '0, '0, 5'd5);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (term_log[i] !== W'(exp_terms[i])) begin
                miscompares++;
                $display("[TB] FAIL lucas_term%0d got %0d want %0d", i, term_log[i], exp_terms[i]);
            end
        end
        vectors++;
        if (run_result !== W'(11) || run_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL lucas_result got %0d/%0b want 11/0", run_result, run_ovf); end
        run_seq(2'b11, W'(7), W'(9), 5'd5);
        vectors++;
        if (run_result !== W'(5) || run_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL mode3_result got %0d/%0b want 5/0", run_result, run_ovf); end
    endtask

    task automatic test_saturation();
        run_seq(2'b00, '0, '0, 5'd30);
        vectors++;
        if (run_result !== W'(832040) || run_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL fib30 got %0d/%0b want 832040/0", run_result, run_ovf); end
        run_seq(2'b00, '0, '0, 5'd31);
        vectors++;
        if (run_result !== 20'hFFFFF || run_ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL fib31 got %0h/%0b want fffff/1", run_result, run_ovf); end
        vectors++;
        if (done_cycle != 33) begin miscompares++; $display("[TB] FAIL fib31_latency got %0d want 33", done_cycle); end
        run_seq(2'b10, 20'hFFFFF, W'(1), 5'd2);
        vectors++;
        if (term_log[0] !== 20'hFFFFF || term_log[1] !== W'(1) || term_log[2] !== 20'hFFFFF) begin miscompares++; $display("[TB] FAIL custom_sat_stream got %0h,%0h,%0h want fffff,1,fffff", term_log[0], term_log[1], term_log[2]); end
        vectors++;
        if (run_result !== 20'hFFFFF || run_ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL custom_sat got %0h/%0b want fffff/1", run_result, run_ovf); end
        run_seq(2'b10, W'(3), W'(4), 5'd4);
        vectors++;
        if (run_result !== W'(18) || run_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL custom_3_4 got %0d/%0b want 18/0", run_result, run_ovf); end
    endtask

    task automatic test_abort();
        logic done_seen;
        run_seq(2'b00, '0, '0, 5'd5);
        vectors++;
        if (run_result !== W'(5)) begin miscompares++; $display("[TB] FAIL abort_setup got %0d want 5", run_result); end
        @(posedge clk); #1;
        mode  = 2'b00;
        n_in  = 5'd10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = 5'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (term_valid !== 1'b1 || term_idx !== 5'd2) begin miscompares++; $display("[TB] FAIL start_ignored got valid=%0b idx=%0d want 1/2", term_valid, term_idx); end
        @(posedge clk); #1;
        vectors++;
        if (term_idx !== 5'd3 || term !== W'(2)) begin miscompares++; $display("[TB] FAIL abort_idx3 got %0d@%0d want 2@3", term, term_idx); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        vectors++;
        if (ready !== 1'b1 || term_valid !== 1'b0 || done_tick !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_exit got ready=%0b valid=%0b done=%0b want 1/0/0", ready, term_valid, done_tick); end
        done_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done_tick) done_seen = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if (done_seen !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_no_done got %0b want 0", done_seen); end
        vectors++;
        if (result !== W'(5)) begin miscompares++; $display("[TB] FAIL abort_result_held got %0d want 5", result); end
    endtask

    task automatic test_async_reset();
        logic done_seen;
        @(posedge clk); #1;
        mode  = 2'b00;
        n_in  = 5'd10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if (ready !== 1'b1 || term_valid !== 1'b0 || done_tick !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_strobes got ready=%0b valid=%0b done=%0b want 1/0/0", ready, term_valid, done_tick); end
        vectors++;
        if (result !== '0 || ovf !== 1'b0 || term !== '0 || term_idx !== '0) begin miscompares++; $display("[TB] FAIL areset_regs got res=%0h ovf=%0b term=%0h idx=%0d want all 0", result, ovf, term, term_idx); end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done_tick) done_seen = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if (done_seen !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_no_done got %0b want 0", done_seen); end
        run_seq(2'b00, '0, '0, 5'd1);
        vectors++;
        if (run_result !== W'(1) || done_cycle != 3) begin miscompares++; $display("[TB] FAIL areset_rerun got %0d@cyc%0d want 1@cyc3", run_result, done_cycle); end
    endtask

    task automatic test_back_to_back();
        run_seq(2'b00, '0, '0, 5'd2);
        vectors++;
        if (run_result !== W'(1)) begin miscompares++; $display("[TB] FAIL b2b_first got %0d want 1", run_result); end
        run_seq(2'b01, '0, '0, 5'd3);
        vectors++;
        if (ready_seen !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready got %0b want 1", ready_seen); end
        vectors++;
        if (run_result !== W'(4) || done_cycle != 5) begin miscompares++; $display("[TB] FAIL b2b_second got %0d@cyc%0d want 4@cyc5", run_result, done_cycle); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = 2'b00;
        seed0 = '0;
        seed1 = '0;
        n_in  = '0;
        test_reset();
        test_fib_n0();
        test_fib_n10();
        test_lucas_and_mode3();
        test_saturation();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
